data_mem_responder: RTL and testbench



---
 rtl/data_mem_pkg.sv | 19 +
 rtl/data_mem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants, FSM encoding and address check for data_mem_responder.
// Optional parity feature is selected by DATA_MEM_PARITY_EN.
package data_mem_pkg;

    localparam int unsigned DefDepth = 256;
    localparam int unsigned DefAw    = 8;
    localparam int unsigned DefCntW  = 16;

    typedef enum logic {
        StClear = 1'b0,
        StIdle  = 1'b1
    } state_e;

    // Word-aligned and inside the array: low two bits zero, everything above the index zero.
    function automatic logic addr_valid(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
// WIDTH is 33 when the parity bit is carried (DATA_MEM_PARITY_EN), otherwise 32.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory slave on the MEM-stage daddrbus/databus pair.
// Clears the array after reset, serves loads combinationally, captures stores at the edge,
// keeps sticky error flags and load/store counters.
// Define DATA_MEM_PARITY_EN to add a per-word even-parity bit with par_err / inj_par ports.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      daddrbus,
    inout  wire  [31:0]      databus,
    input  logic             lw_en,
    input  logic             sw_en,
    output logic             busy,
    output logic             addr_err,
    output logic             cmd_err,
`ifdef DATA_MEM_PARITY_EN
    output logic             par_err,
    input  logic             inj_par,
`endif
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

`ifdef DATA_MEM_PARITY_EN
    localparam int unsigned Width = 33;
`else
    localparam int unsigned Width = 32;
`endif

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic [AW-1:0]    word_idx;
    logic             addr_ok;
    logic             idle;
    logic             load_req;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [Width-1:0] wdata;
    logic [Width-1:0] rdata;
    logic [31:0]      rd_word;

    assign word_idx = daddrbus[AW+1:2];
    assign addr_ok  = addr_valid(daddrbus, AW);
    assign idle     = (state_q == StIdle);
    assign busy     = (state_q == StClear);
    // Both strobes high is a store, so a load only counts with sw_en low.
    assign load_req = lw_en & ~sw_en;

    // State register and clear index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: walk the clear index once, then park in idle until reset.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            StClear: begin
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            StIdle: ;
            default: state_d = StClear;
        endcase
    end

    // Write port mux: clearing owns the port while busy, valid stores own it when idle.
    always_comb begin
        we    = 1'b0;
        waddr = word_idx;
        wdata = '0;
        if (busy) begin
            we    = 1'b1;
            waddr = clr_idx_q;
        end else if (sw_en && addr_ok) begin
            we = 1'b1;
`ifdef DATA_MEM_PARITY_EN
            wdata = {(^databus) ^ inj_par, databus};
`else
            wdata = databus;
`endif
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (Width)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (word_idx),
        .rdata (rdata)
    );

    assign rd_word = (idle && addr_ok) ? rdata[31:0] : 32'h0;
    assign databus = load_req ? rd_word : 32'hzzzz_zzzz;

    // Sticky error flags and transaction counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err  <= 1'b0;
            cmd_err   <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (idle && (lw_en || sw_en) && !addr_ok) begin
                addr_err <= 1'b1;
            end
            if ((lw_en && sw_en) || (busy && sw_en)) begin
                cmd_err <= 1'b1;
            end
            if (idle && load_req) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (idle && sw_en && addr_ok) begin
                store_cnt <= store_cnt + 1'b1;
            end
        end
    end

`ifdef DATA_MEM_PARITY_EN
    // Parity checker: stored bit must equal the recomputed even parity of the loaded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (idle && load_req && addr_ok && ((^rdata[31:0]) != rdata[32])) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder.
// Parity scenario is built only when DATA_MEM_PARITY_EN is defined.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] daddrbus;
    logic        lw_en;
    logic        sw_en;
    logic        busy;
    logic        addr_err;
    logic        cmd_err;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
    logic [31:0] tb_drv;
    logic        tb_oe;
    wire  [31:0] databus;
`ifdef DATA_MEM_PARITY_EN
    logic        par_err;
    logic        inj_par;
`endif

    int checks;
    int failures;
    int exp_load;
    int exp_store;

    assign databus = tb_oe ? tb_drv : 32'hzzzz_zzzz;

    data_mem_responder #(
        .DEPTH (256),
        .AW    (8),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .daddrbus  (daddrbus),
        .databus   (databus),
        .lw_en     (lw_en),
        .sw_en     (sw_en),
        .busy      (busy),
        .addr_err  (addr_err),
        .cmd_err   (cmd_err),
`ifdef DATA_MEM_PARITY_EN
        .par_err   (par_err),
        .inj_par   (inj_par),
`endif
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        lw_en    = 1'b0;
        sw_en    = 1'b0;
        tb_oe    = 1'b0;
        tb_drv   = 32'h0;
        daddrbus = 32'h0;
    endtask

    // Counts edges until busy drops, bounded so a stuck clear cannot hang the run.
    task automatic wait_clear(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        int n;
        idle_bus();
        rst_n = 1'b0;
        #3;
        checks += 5;
        if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b want 1", busy); end
        if (addr_err !== 1'b0) begin failures++; $display("FAIL rst_addr_err: got %b want 0", addr_err); end
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
        if (load_cnt !== 16'd0) begin failures++; $display("FAIL rst_load_cnt: got %0d want 0", load_cnt); end
        if (store_cnt !== 16'd0) begin failures++; $display("FAIL rst_store_cnt: got %0d want 0", store_cnt); end
        tick();
        rst_n = 1'b1;
        wait_clear(n);
        checks++;
        if (n != 256) begin failures++; $display("FAIL clear_len: got %0d cycles want 256", n); end
        daddrbus = 32'h0000_0010;
        lw_en    = 1'b1;
        #3;
        checks++;
        if (databus !== 32'h0) begin failures++; $display("FAIL cleared_load: got %h want 00000000", databus); end
        tick();
        lw_en    = 1'b0;
        exp_load = 1;
        exp_store = 0;
        checks++;
        if (load_cnt !== 16'(exp_load)) begin failures++; $display("FAIL first_load_cnt: got %0d want %0d", load_cnt, exp_load); end
    endtask

    task automatic test_store_load();
        daddrbus = 32'h0000_0008;
        tb_drv   = 32'hDEAD_BEEF;
        tb_oe    = 1'b1;
        sw_en    = 1'b1;
        tick();
        sw_en = 1'b0;
        tb_oe = 1'b0;
        lw_en = 1'b1;
        #3;
        checks++;
        if (databus !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_ld_data: got %h want deadbeef", databus); end
        tick();
        lw_en = 1'b0;
        exp_load++;
        exp_store++;
        checks += 2;
        if (store_cnt !== 16'(exp_store)) begin failures++; $display("FAIL st_ld_store_cnt: got %0d want %0d", store_cnt, exp_store); end
        if (load_cnt !== 16'(exp_load)) begin failures++; $display("FAIL st_ld_load_cnt: got %0d want %0d", load_cnt, exp_load); end
    endtask

    task automatic test_addr_err();
        checks++;
        if (addr_err !== 1'b0) begin failures++; $display("FAIL addr_err_pre: got %b want 0", addr_err); end
        // Word 0 gets known data so aliasing of bad addresses onto it is visible.
        daddrbus = 32'h0000_0000;
        tb_drv   = 32'h1111_1111;
        tb_oe    = 1'b1;
        sw_en    = 1'b1;
        tick();
        exp_store++;
        daddrbus = 32'h0000_0006;
        tb_drv   = 32'hCAFE_F00D;
        tick();
        sw_en = 1'b0;
        tb_oe = 1'b0;
        checks += 2;
        if (addr_err !== 1'b1) begin failures++; $display("FAIL misalign_flag: got %b want 1", addr_err); end
        if (store_cnt !== 16'(exp_store)) begin failures++; $display("FAIL misalign_store_cnt: got %0d want %0d", store_cnt, exp_store); end
        daddrbus = 32'h0000_0004;
        lw_en    = 1'b1;
        #3;
        checks++;
        if (databus !== 32'h0) begin failures++; $display("FAIL misalign_no_write: got %h want 00000000", databus); end
        tick();
        exp_load++;
        daddrbus = 32'h0000_0400;
        #3;
        checks++;
        if (databus !== 32'h0) begin failures++; $display("FAIL range_load_zero: got %h want 00000000", databus); end
        tick();
        exp_load++;
        daddrbus = 32'h0000_0002;
        #3;
        checks++;
        if (databus !== 32'h0) begin failures++; $display("FAIL misalign_load_zero: got %h want 00000000", databus); end
        tick();
        exp_load++;
        lw_en = 1'b0;
        checks++;
        if (load_cnt !== 16'(exp_load)) begin failures++; $display("FAIL bad_load_cnt: got %0d want %0d", load_cnt, exp_load); end
    endtask

    task automatic test_both_strobes();
        checks++;
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL cmd_err_pre: got %b want 0", cmd_err); end
        daddrbus = 32'h0000_000C;
        tb_drv   = 32'h1234_5678;
        tb_oe    = 1'b1;
        lw_en    = 1'b1;
        sw_en    = 1'b1;
        tick();
        lw_en = 1'b0;
        sw_en = 1'b0;
        tb_oe = 1'b0;
        exp_store++;
        checks += 3;
        if (cmd_err !== 1'b1) begin failures++; $display("FAIL both_cmd_err: got %b want 1", cmd_err); end
        if (store_cnt !== 16'(exp_store)) begin failures++; $display("FAIL both_store_cnt: got %0d want %0d", store_cnt, exp_store); end
        if (load_cnt !== 16'(exp_load)) begin failures++; $display("FAIL both_load_cnt: got %0d want %0d", load_cnt, exp_load); end
        lw_en = 1'b1;
        #3;
        checks++;
        if (databus !== 32'h1234_5678) begin failures++; $display("FAIL both_written: got %h want 12345678", databus); end
        tick();
        exp_load++;
        // Word 0 holds 11111111; with both strobes the block must leave the bus alone.
        daddrbus = 32'h0000_0000;
        sw_en    = 1'b1;
        #3;
        checks++;
        if (databus === 32'h1111_1111) begin failures++; $display("FAIL both_no_drive: got %h want undriven", databus); end
        tick();
        exp_store++;
        idle_bus();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        tick();
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        // Word 2 still holds deadbeef here; a busy load must not expose it.
        daddrbus = 32'h0000_0008;
        lw_en    = 1'b1;
        #1;
        checks++;
        if (databus !== 32'h0) begin failures++; $display("FAIL busy_load_zero: got %h want 00000000", databus); end
        tick();
        lw_en    = 1'b0;
        daddrbus = 32'h0000_0010;
        tb_drv   = 32'hAAAA_5555;
        tb_oe    = 1'b1;
        sw_en    = 1'b1;
        tick();
        idle_bus();
        checks += 4;
        if (load_cnt !== 16'd0) begin failures++; $display("FAIL busy_load_cnt: got %0d want 0", load_cnt); end
        if (store_cnt !== 16'd0) begin failures++; $display("FAIL busy_store_cnt: got %0d want 0", store_cnt); end
        if (cmd_err !== 1'b1) begin failures++; $display("FAIL busy_store_cmd_err: got %b want 1", cmd_err); end
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid: got %b want 1", busy); end
        repeat (98) tick();
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy: got %b want 1", busy); end
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL abort_cmd_err: got %b want 0", cmd_err); end
        if (addr_err !== 1'b0) begin failures++; $display("FAIL abort_addr_err: got %b want 0", addr_err); end
        if (load_cnt !== 16'd0) begin failures++; $display("FAIL abort_load_cnt: got %0d want 0", load_cnt); end
        tick();
        rst_n = 1'b1;
        wait_clear(n);
        checks++;
        if (n != 256) begin failures++; $display("FAIL restart_len: got %0d cycles want 256", n); end
        daddrbus = 32'h0000_0008;
        lw_en    = 1'b1;
        #3;
        checks++;
        if (databus !== 32'h0) begin failures++; $display("FAIL recleared_word: got %h want 00000000", databus); end
        tick();
        lw_en     = 1'b0;
        exp_load  = 1;
        exp_store = 0;
        checks++;
        if (load_cnt !== 16'(exp_load)) begin failures++; $display("FAIL restart_load_cnt: got %0d want %0d", load_cnt, exp_load); end
    endtask

`ifdef DATA_MEM_PARITY_EN
    task automatic test_parity();
        inj_par  = 1'b0;
        daddrbus = 32'h0000_0024;
        tb_drv   = 32'h0000_0003;
        tb_oe    = 1'b1;
        sw_en    = 1'b1;
        tick();
        sw_en = 1'b0;
        tb_oe = 1'b0;
        lw_en = 1'b1;
        tick();
        lw_en = 1'b0;
        checks++;
        if (par_err !== 1'b0) begin failures++; $display("FAIL par_clean: got %b want 0", par_err); end
        daddrbus = 32'h0000_0020;
        tb_drv   = 32'h0000_0001;
        tb_oe    = 1'b1;
        sw_en    = 1'b1;
        inj_par  = 1'b1;
        tick();
        sw_en   = 1'b0;
        tb_oe   = 1'b0;
        inj_par = 1'b0;
        lw_en   = 1'b1;
        #3;
        checks++;
        if (databus !== 32'h0000_0001) begin failures++; $display("FAIL par_data: got %h want 00000001", databus); end
        tick();
        lw_en = 1'b0;
        checks++;
        if (par_err !== 1'b1) begin failures++; $display("FAIL par_err_set: got %b want 1", par_err); end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        exp_load  = 0;
        exp_store = 0;
`ifdef DATA_MEM_PARITY_EN
        inj_par = 1'b0;
`endif
        test_reset();
        test_store_load();
        test_addr_err();
        test_both_strobes();
        test_reset_mid_clear();
`ifdef DATA_MEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
